// File: rtl/pe_tap_sequencer.sv
// pe_tap_sequencer
// Sequences a row of NUM_PE lockstep PEs over one job. A job is cfg_oc output
// channels of cfg_taps kernel taps each. For every channel the block:
//   - issues one SRAM read per tap (ifmap, weight and bias addresses),
//   - enables the PEs one cycle later, selecting the bias on tap 0 only,
//   - accumulates the per-tap PE results into one 32-bit sum per lane,
//   - offers the finished sums downstream over a valid/ready handshake.
// Optional build macro ACC_SAT_EN: the accumulation saturates to signed 32-bit
// instead of wrapping.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             job start pulse, latches cfg_taps/cfg_oc when idle
//   cfg_taps, cfg_oc  taps per output channel, output channels per job
//   busy, done        job in progress / one-cycle completion pulse
//   rd_en             SRAM read strobe (data returns next cycle)
//   if_addr, w_addr   ifmap address (tap), weight address (running counter)
//   b_addr            bias address (current output channel)
//   pe_en             PE input strobe, rd_en delayed one cycle
//   pe_bias_sel       PE bias comes from the bias SRAM (1) or is zero (0)
//   pe_valid          PE result strobe (PE0, all lanes lockstep)
//   pe_opsum          PE results, PE0 in the LSBs
//   acc_out, out_oc   accumulated sums and their output channel
//   out_valid         acc_out valid, held until out_ready
//   out_ready         downstream accepts acc_out

module pe_tap_sequencer #(
    parameter int unsigned NUM_PE = 4,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned TAP_W  = 8,
    parameter int unsigned OC_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [TAP_W-1:0]     cfg_taps,
    input  logic [OC_W-1:0]      cfg_oc,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    if_addr,
    output logic [ADDR_W-1:0]    w_addr,
    output logic [OC_W-1:0]      b_addr,
    output logic                 pe_en,
    output logic                 pe_bias_sel,
    input  logic                 pe_valid,
    input  logic [NUM_PE*32-1:0] pe_opsum,
    output logic [NUM_PE*32-1:0] acc_out,
    output logic [OC_W-1:0]      out_oc,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int unsigned ACC_W   = 32;
    localparam int unsigned LANES_W = NUM_PE * ACC_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUT,
        S_FIN
    } state_t;

    // Tag travelling alongside each read so the accumulator knows what it sees.
    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } tag_t;

    state_t              state_q, state_d;
    logic [TAP_W-1:0]    taps_q, taps_d;
    logic [OC_W-1:0]     ocn_q, ocn_d;
    logic [OC_W-1:0]     oc_q, oc_d;
    logic [TAP_W-1:0]    tap_q, tap_d;
    logic [ADDR_W-1:0]   w_cnt_q, w_cnt_d;
    logic [LANES_W-1:0]  acc_q, acc_d;

    logic                rd_en_q;
    logic                pe_en_q;
    logic                bias_sel_q;
    logic                busy_q;
    logic                done_q;
    logic                out_valid_q;
    tag_t                tag1_q, tag1_d;
    tag_t                tag2_q;

    logic                tap_last_c;
    logic                oc_last_c;

    assign tap_last_c = (tap_q == taps_q - TAP_W'(1));
    assign oc_last_c  = (oc_q == ocn_q - OC_W'(1));

    // One accumulation step; saturating only when ACC_SAT_EN is defined.
    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W-1:0] s;
        s = a + b;
`ifdef ACC_SAT_EN
        if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1])) begin
            s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
`else
        s = s;
`endif
        return s;
    endfunction

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        taps_d  = taps_q;
        ocn_d   = ocn_q;
        oc_d    = oc_q;
        tap_d   = tap_q;
        w_cnt_d = w_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    taps_d = cfg_taps;
                    ocn_d  = cfg_oc;
                    if ((cfg_taps == '0) || (cfg_oc == '0)) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_ISSUE;
                        oc_d    = '0;
                        tap_d   = '0;
                        w_cnt_d = '0;
                    end
                end
            end
            S_ISSUE: begin
                // Weight address runs on across channels: oc*taps + tap.
                w_cnt_d = w_cnt_q + ADDR_W'(1);
                if (tap_last_c) begin
                    state_d = S_DRAIN;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            S_DRAIN: begin
                // Last tap reaches the accumulator this cycle.
                if (tag2_q.vld && tag2_q.last) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (oc_last_c) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_ISSUE;
                        oc_d    = oc_q + OC_W'(1);
                        tap_d   = '0;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Tag for the read issued this cycle.
    always_comb begin
        tag1_d       = '0;
        tag1_d.vld   = rd_en_q;
        tag1_d.first = rd_en_q && (tap_q == '0);
        tag1_d.last  = rd_en_q && tap_last_c;
    end

    // Per-lane accumulate; untagged pe_valid pulses are ignored.
    always_comb begin
        acc_d = acc_q;
        if (pe_valid && tag2_q.vld) begin
            for (int i = 0; i < NUM_PE; i++) begin
                acc_d[i*ACC_W +: ACC_W] = tag2_q.first ? pe_opsum[i*ACC_W +: ACC_W]
                                        : acc_add(acc_q[i*ACC_W +: ACC_W],
                                                  pe_opsum[i*ACC_W +: ACC_W]);
            end
        end
    end

    // State, counters, tag pipeline and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            taps_q      <= '0;
            ocn_q       <= '0;
            oc_q        <= '0;
            tap_q       <= '0;
            w_cnt_q     <= '0;
            acc_q       <= '0;
            rd_en_q     <= 1'b0;
            pe_en_q     <= 1'b0;
            bias_sel_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            tag1_q      <= '0;
            tag2_q      <= '0;
        end else begin
            state_q     <= state_d;
            taps_q      <= taps_d;
            ocn_q       <= ocn_d;
            oc_q        <= oc_d;
            tap_q       <= tap_d;
            w_cnt_q     <= w_cnt_d;
            acc_q       <= acc_d;
            rd_en_q     <= (state_d == S_ISSUE);
            pe_en_q     <= rd_en_q;
            bias_sel_q  <= tag1_d.first;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_q == S_FIN);
            out_valid_q <= (state_d == S_OUT);
            tag1_q      <= tag1_d;
            tag2_q      <= tag1_q;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign rd_en       = rd_en_q;
    assign if_addr     = ADDR_W'(tap_q);
    assign w_addr      = w_cnt_q;
    assign b_addr      = oc_q;
    assign pe_en       = pe_en_q;
    assign pe_bias_sel = bias_sel_q;
    assign acc_out     = acc_q;
    assign out_oc      = oc_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_pe_tap_sequencer.sv
`timescale 1ns/1ps
module tb_pe_tap_sequencer;

    localparam int unsigned NUM_PE = 4;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned TAP_W  = 8;
    localparam int unsigned OC_W   = 8;
`ifdef ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [TAP_W-1:0]     cfg_taps;
    logic [OC_W-1:0]      cfg_oc;
    logic                 busy, done, rd_en, pe_en, pe_bias_sel;
    logic [ADDR_W-1:0]    if_addr, w_addr;
    logic [OC_W-1:0]      b_addr, out_oc;
    logic                 pe_valid;
    logic [NUM_PE*32-1:0] pe_opsum;
    logic [NUM_PE*32-1:0] acc_out;
    logic                 out_valid;
    logic                 out_ready;

    pe_tap_sequencer #(.NUM_PE(NUM_PE), .ADDR_W(ADDR_W), .TAP_W(TAP_W), .OC_W(OC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_taps(cfg_taps), .cfg_oc(cfg_oc),
        .busy(busy), .done(done), .rd_en(rd_en), .if_addr(if_addr), .w_addr(w_addr),
        .b_addr(b_addr), .pe_en(pe_en), .pe_bias_sel(pe_bias_sel), .pe_valid(pe_valid),
        .pe_opsum(pe_opsum), .acc_out(acc_out), .out_oc(out_oc), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s @%0t", name, $time);
    endtask

    // SRAM contents: per-address operand and per-channel bias.
    logic [31:0] op_tab   [64];
    logic [31:0] bias_tab [16];

    function automatic logic [31:0] pe_lane(input logic [ADDR_W-1:0] wa, input logic [OC_W-1:0] ba,
                                            input logic sel, input int j);
        return op_tab[wa[5:0]] + 32'(j) + (sel ? bias_tab[ba[3:0]] : 32'd0);
    endfunction

    // SRAM (1-cycle read) + PE row (1-cycle compute) model.
    logic [ADDR_W-1:0] wa_q;
    logic [OC_W-1:0]   ba_q;
    always @(posedge clk) begin
        wa_q     <= w_addr;
        ba_q     <= b_addr;
        pe_valid <= pe_en;
        if (pe_en) begin
            for (int j = 0; j < NUM_PE; j++) begin
                pe_opsum[j*32 +: 32] <= pe_lane(wa_q, ba_q, pe_bias_sel, j);
            end
        end
    end

    // Reference accumulation step.
    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (SAT) begin
            if (s > SMAX) s = SMAX;
            else if (s < SMIN) s = SMIN;
        end
        return s[31:0];
    endfunction

    typedef struct packed {
        logic [ADDR_W-1:0] ia;
        logic [ADDR_W-1:0] wa;
        logic [OC_W-1:0]   ba;
    } rd_t;

    rd_t                  rd_q[$];
    bit                   bq[$];
    logic [NUM_PE*32-1:0] exp_acc[$];
    int                   exp_oc[$];

    // Expected reads, bias selects and channel results for one job.
    task automatic build_expect(input int taps, input int ocs);
        rd_t                  e;
        logic [NUM_PE*32-1:0] v;
        logic [31:0]          a;
        logic [31:0]          op;
        if (taps == 0 || ocs == 0) return;
        for (int oc = 0; oc < ocs; oc++) begin
            for (int t = 0; t < taps; t++) begin
                e.ia = ADDR_W'(t);
                e.wa = ADDR_W'(oc * taps + t);
                e.ba = OC_W'(oc);
                rd_q.push_back(e);
                bq.push_back(t == 0);
            end
            for (int j = 0; j < NUM_PE; j++) begin
                a = 32'd0;
                for (int t = 0; t < taps; t++) begin
                    op = op_tab[(oc * taps + t) % 64] + 32'(j) + ((t == 0) ? bias_tab[oc % 16] : 32'd0);
                    a  = (t == 0) ? op : model_add(a, op);
                end
                v[j*32 +: 32] = a;
            end
            exp_acc.push_back(v);
            exp_oc.push_back(oc);
        end
    endtask

    // Compare process.
    logic [NUM_PE*32-1:0] prev_acc, last_acc;
    logic [OC_W-1:0]      prev_oc, last_oc;
    bit                   prev_hold = 1'b0;
    int                   done_cnt  = 0;
    always @(negedge clk) begin
        rd_t                  e;
        logic [NUM_PE*32-1:0] v;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (rd_en) begin
                check("rd_en_during_out_valid", 64'(out_valid), 64'd0);
                if (rd_q.size() == 0) begin
                    fail_now("unexpected_rd_en");
                end else begin
                    e = rd_q.pop_front();
                    check("if_addr", 64'(if_addr), 64'(e.ia));
                    check("w_addr", 64'(w_addr), 64'(e.wa));
                    check("b_addr", 64'(b_addr), 64'(e.ba));
                end
            end
            if (pe_en) begin
                if (bq.size() == 0) fail_now("unexpected_pe_en");
                else check("pe_bias_sel", 64'(pe_bias_sel), 64'(bq.pop_front()));
            end else begin
                check("pe_bias_sel_idle", 64'(pe_bias_sel), 64'd0);
            end
            if (out_valid) begin
                if (prev_hold) begin
                    check("hold_out_oc", 64'(out_oc), 64'(prev_oc));
                    for (int j = 0; j < NUM_PE; j++)
                        check("hold_acc_out", 64'(acc_out[j*32 +: 32]), 64'(prev_acc[j*32 +: 32]));
                end
                if (out_ready) begin
                    if (exp_acc.size() == 0) begin
                        fail_now("unexpected_out_transfer");
                    end else begin
                        v = exp_acc.pop_front();
                        check("out_oc", 64'(out_oc), 64'(exp_oc.pop_front()));
                        for (int j = 0; j < NUM_PE; j++)
                            check("acc_out_lane", 64'(acc_out[j*32 +: 32]), 64'(v[j*32 +: 32]));
                    end
                    last_acc  = acc_out;
                    last_oc   = out_oc;
                    prev_hold = 1'b0;
                end else begin
                    prev_hold = 1'b1;
                    prev_acc  = acc_out;
                    prev_oc   = out_oc;
                end
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    // Downstream ready: 0 always ready, 1 hold off 5 cycles per output, 2 random.
    int ready_mode = 0;
    initial begin
        int hold;
        hold      = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            hold = out_valid ? hold + 1 : 0;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (hold > 5);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    bit job_active = 1'b0;

    task automatic noise_proc();
        while (job_active) begin
            @(posedge clk);
            #2;
            if (busy && ($urandom_range(0, 2) == 0)) begin
                start    = 1'b1;
                cfg_taps = TAP_W'($urandom_range(0, 9));
                cfg_oc   = OC_W'($urandom_range(0, 9));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic run_job(input int taps, input int ocs, input int mode, input bit noise,
                           output int lat);
        int dc0;
        int cyc;
        build_expect(taps, ocs);
        ready_mode = mode;
        dc0        = done_cnt;
        @(posedge clk);
        #2;
        cfg_taps = TAP_W'(taps);
        cfg_oc   = OC_W'(ocs);
        start    = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", 64'(busy), 64'd1);
        job_active = 1'b1;
        cyc        = 1;
        fork
            if (noise) noise_proc();
            begin
                while (!done && cyc < 2000) begin
                    @(negedge clk);
                    cyc++;
                end
                if (!done) fail_now("done_timeout");
                job_active = 1'b0;
            end
        join
        lat = cyc;
        @(negedge clk);
        check("done_pulse_width", 64'(done), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        check("done_count", 64'(done_cnt - dc0), 64'd1);
        check("rd_queue_drained", 64'(rd_q.size()), 64'd0);
        check("out_queue_drained", 64'(exp_acc.size()), 64'd0);
        rd_q.delete();
        bq.delete();
        exp_acc.delete();
        exp_oc.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_rd_en"}, 64'(rd_en), 64'd0);
        check({tag, "_pe_en"}, 64'(pe_en), 64'd0);
        check({tag, "_bias_sel"}, 64'(pe_bias_sel), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_if_addr"}, 64'(if_addr), 64'd0);
        check({tag, "_w_addr"}, 64'(w_addr), 64'd0);
        check({tag, "_b_addr"}, 64'(b_addr), 64'd0);
        check({tag, "_out_oc"}, 64'(out_oc), 64'd0);
        for (int j = 0; j < NUM_PE; j++)
            check({tag, "_acc_out"}, 64'(acc_out[j*32 +: 32]), 64'd0);
    endtask

    task automatic reset_mid_job();
        int n;
        int dc;
        for (int i = 0; i < 64; i++) op_tab[i] = 32'($urandom_range(0, 1000));
        build_expect(4, 3);
        ready_mode = 0;
        @(posedge clk);
        #2;
        cfg_taps = TAP_W'(4);
        cfg_oc   = OC_W'(3);
        start    = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        n     = 0;
        @(negedge clk);
        while (!(rd_en && b_addr == OC_W'(1) && if_addr == ADDR_W'(1)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("mid_reset_trigger_timeout");
        dc = done_cnt;
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rd_q.delete();
        bq.delete();
        exp_acc.delete();
        exp_oc.delete();
        #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_acc_lane0", 64'(acc_out[31:0]), 64'd0);
            check("post_rst_out_valid", 64'(out_valid), 64'd0);
            check("post_rst_rd_en", 64'(rd_en), 64'd0);
        end
        check("no_done_after_rst", 64'(done_cnt), 64'(dc));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout @%0t", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int lat;
        rst      = 1'b1;
        start    = 1'b0;
        cfg_taps = '0;
        cfg_oc   = '0;
        for (int i = 0; i < 64; i++) op_tab[i] = 32'd0;
        for (int i = 0; i < 16; i++) bias_tab[i] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        #1 rst = 1'b0;

        // Basic job: 3 taps of 10,20,30 per channel, two channels.
        op_tab[0] = 32'd10; op_tab[1] = 32'd20; op_tab[2] = 32'd30;
        op_tab[3] = 32'd10; op_tab[4] = 32'd20; op_tab[5] = 32'd30;
        run_job(3, 2, 0, 1'b0, lat);
        check("basic_lane0", 64'(last_acc[31:0]), 64'd60);
        check("basic_lane1", 64'(last_acc[63:32]), 64'd63);
        check("basic_last_oc", 64'(last_oc), 64'd1);

        // Backpressure: 5 cycles of out_ready low per output.
        run_job(3, 2, 1, 1'b0, lat);
        check("bp_lane0", 64'(last_acc[31:0]), 64'd60);
        check("bp_lane3", 64'(last_acc[127:96]), 64'd69);

        // Degenerate configurations.
        run_job(0, 3, 0, 1'b0, lat);
        check("taps0_done_latency", 64'(lat), 64'd2);
        run_job(5, 0, 0, 1'b0, lat);
        check("oc0_done_latency", 64'(lat), 64'd2);

        // Single tap: result is the tap's opsum including bias.
        op_tab[0]   = 32'd5;
        bias_tab[0] = 32'd100;
        run_job(1, 1, 0, 1'b0, lat);
        check("tap1_lane0", 64'(last_acc[31:0]), 64'd105);
        check("tap1_lane2", 64'(last_acc[95:64]), 64'd107);
        bias_tab[0] = 32'd0;

        // Positive overflow.
        op_tab[0] = 32'h7FFF_FFF0;
        op_tab[1] = 32'h0000_0020;
        run_job(2, 1, 0, 1'b0, lat);
        check("ovf_pos_lane0", 64'(last_acc[31:0]), SAT ? 64'h7FFF_FFFF : 64'h8000_0010);

        // Negative overflow.
        op_tab[0] = 32'h8000_0000;
        op_tab[1] = 32'hFFFF_FFFF;
        run_job(2, 1, 0, 1'b0, lat);
        check("ovf_neg_lane0", 64'(last_acc[31:0]), SAT ? 64'h8000_0000 : 64'h7FFF_FFFF);

        // Reset during channel 1 issue, then a clean job from channel 0.
        reset_mid_job();
        run_job(2, 2, 0, 1'b0, lat);
        check("post_rst_job_last_oc", 64'(last_oc), 64'd1);

        // Random data and biases, random ready, stray starts while busy.
        for (int i = 0; i < 64; i++) op_tab[i] = $urandom;
        for (int i = 0; i < 16; i++) bias_tab[i] = $urandom;
        run_job(5, 4, 2, 1'b1, lat);
        run_job(3, 3, 2, 1'b1, lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
